// File: rtl/hpgp_turbo_enc.sv
// Duo-binary 8-state turbo constituent encoder pair (P natural, Q interleaved) with block framing.
// Optional rate-16/21 parity puncturing is compiled in with HPGP_PUNCT_16_21_EN.
module hpgp_turbo_enc #(
    parameter int CNT_W       = 12,
    parameter int NUM_PAIRS_0 = 64,
    parameter int NUM_PAIRS_1 = 544,
    parameter int NUM_PAIRS_2 = 2080
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] pb_size,
    input  logic       din_vld,
    input  logic [1:0] din_sys,
    input  logic [1:0] din_itl,
    output logic       dout_vld,
    output logic [1:0] sys_out,
    output logic [1:0] par_out,
    output logic [1:0] par_keep,
    output logic       sop,
    output logic       eop
);
    // valid/ready: no ready exists; every cycle with din_vld=1 consumes one pair, results appear one cycle later with dout_vld=1.
    typedef enum logic {IDLE, RUN} blk_state_t;

    blk_state_t       state_r, state_nx;
    logic [CNT_W-1:0] cnt_r, cnt_nx, n_cur;
    logic [1:0]       size_r, size_nx, size_cur;
    logic [2:0]       sp_r, sp_nx, sq_r, sq_nx;
    logic             fb_p, fb_q, par_p, par_q, last;
    logic [1:0]       keep_nx;

    function automatic logic [CNT_W-1:0] pairs_for(input logic [1:0] code);
        case (code)
            2'd0:    return CNT_W'(NUM_PAIRS_0);
            2'd1:    return CNT_W'(NUM_PAIRS_1);
            default: return CNT_W'(NUM_PAIRS_2);
        endcase
    endfunction

    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        size_nx  = size_r;
        sp_nx    = sp_r;
        sq_nx    = sq_r;
        // The first pair of a block takes its size from the live input; later pairs use the latched code.
        size_cur = (state_r == IDLE) ? pb_size : size_r;
        n_cur    = pairs_for(size_cur);
        last     = (cnt_r == n_cur - 1'b1);
        fb_p     = din_sys[1] ^ din_sys[0] ^ sp_r[2];
        fb_q     = din_itl[1] ^ din_itl[0] ^ sq_r[2];
        par_p    = fb_p ^ sp_r[0] ^ sp_r[2];
        par_q    = fb_q ^ sq_r[0] ^ sq_r[2];
`ifdef HPGP_PUNCT_16_21_EN
        // cnt restarts at 0 each block, so its low three bits are the puncturing phase.
        keep_nx  = {(cnt_r[2:0] == 3'd0) || (cnt_r[2:0] == 3'd3) || (cnt_r[2:0] == 3'd6),
                    (cnt_r[2:0] == 3'd0) || (cnt_r[2:0] == 3'd4)};
`else
        keep_nx  = 2'b11;
`endif
        if (din_vld) begin
            size_nx = size_cur;
            if (last) begin
                cnt_nx   = '0;
                state_nx = IDLE;
                sp_nx    = 3'b000;
                sq_nx    = 3'b000;
            end else begin
                cnt_nx   = cnt_r + 1'b1;
                state_nx = RUN;
                sp_nx    = {sp_r[1] ^ din_sys[1], sp_r[0] ^ din_sys[1], fb_p};
                sq_nx    = {sq_r[1] ^ din_itl[1], sq_r[0] ^ din_itl[1], fb_q};
            end
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            size_r  <= 2'b00;
            sp_r    <= 3'b000;
            sq_r    <= 3'b000;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            size_r  <= size_nx;
            sp_r    <= sp_nx;
            sq_r    <= sq_nx;
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            dout_vld <= 1'b0;
            sys_out  <= 2'b00;
            par_out  <= 2'b00;
            par_keep <= 2'b00;
            sop      <= 1'b0;
            eop      <= 1'b0;
        end else begin
            dout_vld <= din_vld;
            if (din_vld) begin
                sys_out  <= din_sys;
                par_out  <= {par_p, par_q};
                par_keep <= keep_nx;
                sop      <= (state_r == IDLE);
                eop      <= last;
            end else begin
                par_keep <= 2'b00;
                sop      <= 1'b0;
                eop      <= 1'b0;
            end
        end
    end
endmodule

// File: doc/hpgp_turbo_enc.md
Name: hpgp_turbo_enc

Overview:
- Constituent-encoder stage directly downstream of the turbo interleaver top.
- Consumes per cycle one natural-order information pair (`rdata`) and the matching interleaved pair (`rdata_itl`), qualified by the interleaver's `dout_vld`.
- Runs two identical 8-state duo-binary recursive systematic encoders: encoder P on natural pairs, encoder Q on interleaved pairs.
- Emits systematic pair plus parity pair (p,q) per input pair, with block framing derived from `pb_size`.

Parameters:
- CNT_W, 12, width of the pair counter; must hold 2079.
- NUM_PAIRS_0, 64, pairs per block for `pb_size`=0 (16-octet PB).
- NUM_PAIRS_1, 544, pairs per block for `pb_size`=1 (136-octet PB).
- NUM_PAIRS_2, 2080, pairs per block for `pb_size`=2 and 3 (520-octet PB; code 3 aliases 2).

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous reset, ACTIVE-HIGH despite the name (1 = reset)
- pb_size  input  2  block size code, sampled on first pair of each block
- din_vld  input  1  pair valid, driven by interleaver `dout_vld`
- din_sys  input  2  natural-order pair {u1,u0}
- din_itl  input  2  interleaved pair {v1,v0}
- dout_vld  output  1  output pair valid
- sys_out  output  2  registered copy of `din_sys`
- par_out  output  2  {p,q}: p from encoder P, q from encoder Q
- par_keep  output  2  {keep_p,keep_q}: parity bit transmitted
- sop  output  1  first pair of block, coincident with `dout_vld`
- eop  output  1  last pair of block, coincident with `dout_vld`

Behaviour:
- Reset: while `n_rst`=1, all outputs are 0 and both encoder states are 3'b000. The pair counter and the latched size are 0. Clearing is immediate (asynchronous), including mid-block; the next valid pair after release starts a new block.
- No backpressure. Every cycle with `din_vld`=1 consumes one pair. Cycles with `din_vld`=0 hold all state, and `dout_vld` drops to 0 on the following edge.
- Latency: exactly 1 cycle. Outputs are registered from the current input and the current state.
- Encoder equations, identical for P and Q. Inputs are (a1,a0); state is s[2:0].
  - fb = a1^a0^s[2]
  - parity = fb^s[0]^s[2]
  - next state s = {s[1]^a1, s[0]^a1, fb}
- Block FSM states:
  - IDLE: cnt=0, no block in progress. On `din_vld`, latch `pb_size`, set N from the table, assert `sop` on the output, go to RUN.
  - RUN: cnt increments per valid pair.
  - Pair with cnt==N-1: assert `eop`, clear cnt, force both encoder states to 000 after that pair, return to IDLE.
  - Block of length 1 is impossible (minimum 64 pairs).
- A `pb_size` change during RUN is ignored until the next block.
- Back-to-back blocks: a valid pair on the cycle after `eop` is the first pair of the next block. No bubble is required.
- `par_keep` is 2'b11 whenever `dout_vld`=1 and 2'b00 otherwise (unless the optional feature is compiled in).

Optional Feature:
- Macro: `HPGP_PUNCT_16_21_EN`.
- Defined: applies the rate-16/21 puncturing mask using phase = cnt mod 8, reset per block.
  - keep_p=1 at phase 0, 3, 6.
  - keep_q=1 at phase 0, 4.
  - 5 parity bits are kept per 8 pairs.
  - `par_out` values are unchanged; only `par_keep` is masked.
- Undefined: no phase logic; `par_keep`=2'b11 on every valid output (rate 1/2).

Test Plan:
- Reset and clear:
  - Stimulus: assert `n_rst`, drive `din_vld`=1 with random data.
  - Required: all outputs stay 0.
  - Stimulus: release reset, drive 64 pairs of 00 with `pb_size`=0.
  - Required: `par_out`=00 throughout, `sop` on output 1, `eop` on output 64.
- Impulse response:
  - Stimulus: `pb_size`=0; first pair `din_sys`=01, `din_itl`=00, then 00 pairs.
  - Required: p sequence 1,1,0,0,1,1,0,0…; q=0 throughout; `sys_out` echoes input one cycle later.
- Size and block restart:
  - Stimulus: `pb_size`=1 for 544 pairs, then `pb_size`=2 immediately (no gap) for 2080 pairs.
  - Required: `eop` at output pairs 544 and 2624; `sop` at 1 and 545.
  - Required: the same impulse applied at pair 545 reproduces the impulse-response sequence (state cleared at block end).
- Valid gaps:
  - Stimulus: impulse block with `din_vld` toggling 1,0,1,0.
  - Required: parity sequence identical to the gapless case; `dout_vld` mirrors `din_vld` delayed by 1.
- Mid-block reset:
  - Stimulus: assert `n_rst` at pair 30 of a 64-pair block, release, then send a fresh 64-pair block.
  - Required: outputs 0 during reset; `sop` on the first new pair; `eop` after 64 pairs.
- `HPGP_PUNCT_16_21_EN` defined:
  - Stimulus: a 64-pair block.
  - Required: `par_keep` per phase 0..7 is 11,00,00,10,01,00,10,00, repeating; total 40 kept parity bits.
